// File: rtl/tcm_arb_pkg.sv
// Shared types and defaults for the TCM data-port arbiter.
// Optional perf counters in the top are enabled by TCM_ARB_PERF_EN.
package tcm_arb_pkg;

  localparam int TAG_W_DEF       = 11;
  localparam int OUTSTANDING_DEF = 2;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_EXT  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  wr;
  } dreq_t;

  function automatic logic req_valid(
    input logic       rd,
    input logic [3:0] wr
  );
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/tcm_arb_id_fifo.sv
// In-flight requester-ID FIFO; head names the owner of the next response.
// Push and pop may coincide, including when full.
module tcm_arb_id_fifo
  import tcm_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic id,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= id;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop)
        rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + CW'(1);
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// Round-robin arbiter sharing one TCM data port between LSU (m0) and loader (m1).
// Define TCM_ARB_PERF_EN to add per-requester accepted-transfer counters.
module tcm_dport_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      m0_addr_i,
  input  logic [31:0]      m0_data_wr_i,
  input  logic             m0_rd_i,
  input  logic [3:0]       m0_wr_i,
  input  logic [TAG_W-1:0] m0_req_tag_i,
  output logic             m0_accept_o,
  output logic             m0_ack_o,
  output logic [31:0]      m0_data_rd_o,
  output logic [TAG_W-1:0] m0_resp_tag_o,
  input  logic [31:0]      m1_addr_i,
  input  logic [31:0]      m1_data_wr_i,
  input  logic             m1_rd_i,
  input  logic [3:0]       m1_wr_i,
  input  logic [TAG_W-1:0] m1_req_tag_i,
  output logic             m1_accept_o,
  output logic             m1_ack_o,
  output logic [31:0]      m1_data_rd_o,
  output logic [TAG_W-1:0] m1_resp_tag_o,
  output logic [31:0]      tcm_addr_o,
  output logic [31:0]      tcm_data_wr_o,
  output logic             tcm_rd_o,
  output logic [3:0]       tcm_wr_o,
  output logic [TAG_W-1:0] tcm_req_tag_o,
  input  logic             tcm_accept_i,
  input  logic             tcm_ack_i,
  input  logic [31:0]      tcm_data_rd_i,
  input  logic [TAG_W-1:0] tcm_resp_tag_i,
`ifdef TCM_ARB_PERF_EN
  input  logic             perf_clr_i,
  output logic [31:0]      perf_m0_cnt_o,
  output logic [31:0]      perf_m1_cnt_o,
`endif
  output logic             err_o
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic room, push, pop;
  logic push_id;
  logic rr_last_q;
  logic fifo_head, fifo_full, fifo_empty;
  dreq_t sel;
  logic [TAG_W-1:0] sel_tag;

  assign req0 = req_valid(m0_rd_i, m0_wr_i);
  assign req1 = req_valid(m1_rd_i, m1_wr_i);

  assign pop  = tcm_ack_i & ~fifo_empty;
  assign room = ~fifo_full | pop;

  // On contention the side that did not win last time goes first.
  assign gnt0 = room & req0 & (~req1 | (rr_last_q == REQ_EXT));
  assign gnt1 = room & req1 & (~req0 | (rr_last_q == REQ_CORE));

  always_comb begin
    sel     = '0;
    sel_tag = '0;
    unique case (1'b1)
      gnt0: begin
        sel     = '{m0_addr_i, m0_data_wr_i, m0_rd_i, m0_wr_i};
        sel_tag = m0_req_tag_i;
      end
      gnt1: begin
        sel     = '{m1_addr_i, m1_data_wr_i, m1_rd_i, m1_wr_i};
        sel_tag = m1_req_tag_i;
      end
      default: ;
    endcase
  end

  assign tcm_addr_o    = sel.addr;
  assign tcm_data_wr_o = sel.data;
  assign tcm_rd_o      = sel.rd;
  assign tcm_wr_o      = sel.wr;
  assign tcm_req_tag_o = sel_tag;

  assign m0_accept_o = gnt0 & tcm_accept_i;
  assign m1_accept_o = gnt1 & tcm_accept_i;
  assign push        = m0_accept_o | m1_accept_o;
  assign push_id     = gnt1 ? REQ_EXT : REQ_CORE;

  tcm_arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .id    (push_id),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m0_ack_o      = pop & (fifo_head == REQ_CORE);
  assign m1_ack_o      = pop & (fifo_head == REQ_EXT);
  assign m0_data_rd_o  = m0_ack_o ? tcm_data_rd_i : '0;
  assign m1_data_rd_o  = m1_ack_o ? tcm_data_rd_i : '0;
  assign m0_resp_tag_o = m0_ack_o ? tcm_resp_tag_i : '0;
  assign m1_resp_tag_o = m1_ack_o ? tcm_resp_tag_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= REQ_EXT;
      err_o     <= 1'b0;
    end else begin
      if (push)
        rr_last_q <= push_id;
      if (tcm_ack_i && fifo_empty)
        err_o <= 1'b1;
    end
  end

`ifdef TCM_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_m0_cnt_o <= '0;
      perf_m1_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_m0_cnt_o <= '0;
      perf_m1_cnt_o <= '0;
    end else begin
      if (m0_accept_o && (perf_m0_cnt_o != 32'hFFFF_FFFF))
        perf_m0_cnt_o <= perf_m0_cnt_o + 32'd1;
      if (m1_accept_o && (perf_m1_cnt_o != 32'hFFFF_FFFF))
        perf_m1_cnt_o <= perf_m1_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/tcm_dport_arbiter.md
Name: tcm_dport_arbiter

Overview:
- Shares the single TCM data port between two requesters:
  - m0: core LSU.
  - m1: external/debug loader or DMA.
- Round-robin grant, with zero-cycle arbitration on the request path.
- Tracks in-flight transactions in a small ID FIFO so that each TCM ack/data/tag is returned to the requester that issued it.
- Sits between the requesters and the TCM data-port inputs (mem_d_*).

Parameters:
- OUTSTANDING, 2, depth of the in-flight ID FIFO; power of two, minimum 2.
- TAG_W, 11, request/response tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m0_addr_i / m1_addr_i  in  32  request byte address.
- m0_data_wr_i / m1_data_wr_i  in  32  write data.
- m0_rd_i / m1_rd_i  in  1  read request.
- m0_wr_i / m1_wr_i  in  4  byte write strobes.
- m0_req_tag_i / m1_req_tag_i  in  TAG_W  request tag.
- m0_accept_o / m1_accept_o  out  1  request accepted this cycle.
- m0_ack_o / m1_ack_o  out  1  response valid.
- m0_data_rd_o / m1_data_rd_o  out  32  read data.
- m0_resp_tag_o / m1_resp_tag_o  out  TAG_W  response tag.
- tcm_addr_o  out  32  muxed address.
- tcm_data_wr_o  out  32  muxed write data.
- tcm_rd_o  out  1  muxed read.
- tcm_wr_o  out  4  muxed strobes.
- tcm_req_tag_o  out  TAG_W  muxed tag.
- tcm_accept_i  in  1  TCM accepts.
- tcm_ack_i  in  1  TCM response valid.
- tcm_data_rd_i  in  32  TCM read data.
- tcm_resp_tag_i  in  TAG_W  TCM response tag.
- err_o  out  1  sticky protocol error.

Behaviour:
- Request definitions:
  - reqN = mN_rd_i | (mN_wr_i != 0).
  - Flush, invalidate and writeback requests are not carried by this port; the TCM side ties them to 0.
- Grant (combinational, same cycle):
  - Only one requester requesting: that requester wins.
  - Both requesting: the requester not granted last wins (rr_last_q).
  - Grant is suppressed while the FIFO is full and no pop is occurring this cycle.
- Downstream request:
  - tcm_* carries the granted requester's fields.
  - With no grant, all tcm_* outputs are 0, so the TCM sees no request.
- Accept and push:
  - mN_accept_o = grantN & tcm_accept_i; the non-granted requester sees accept = 0.
  - An accepted transfer pushes the requester ID (0/1) into the ID FIFO and sets rr_last_q = N.
- Requester hold rule: a requester holds all of its request fields stable until accepted. The arbiter never revokes a grant mid-cycle.
- Response routing:
  - tcm_ack_i pops the FIFO head.
  - mH_ack_o = 1, mH_data_rd_o = tcm_data_rd_i and mH_resp_tag_o = tcm_resp_tag_i for head ID H.
  - The other requester's ack, data and tag outputs are 0.
  - Response path is combinational: responses arrive 1 cycle after accept with a TCM accept-always port, giving a total latency of 1 cycle.
- Simultaneous push and pop:
  - Allowed, including when the FIFO is full; occupancy is unchanged.
  - Pointers wrap modulo OUTSTANDING.
- FIFO empty: tcm_ack_i with an empty FIFO sets err_o (sticky until reset), produces no mN_ack_o, and does not pop.
- Back-to-back: a single requester issuing every cycle is accepted every cycle.
- Fairness: alternating grants under continuous contention from both requesters.
- Reset values:
  - Asserting rst_i at any time clears the FIFO (pointers and count = 0), sets rr_last_q = 1 (m0 has first priority) and sets err_o = 0.
  - All outputs driven from registered state are 0; combinational outputs follow inputs with an empty FIFO.
  - In-flight responses are dropped. The TCM shares rst_i, so no stale acks are expected.

Optional Feature:
- Macro: TCM_ARB_PERF_EN.
- With the macro:
  - Adds ports perf_clr_i (in, 1), perf_m0_cnt_o (out, 32) and perf_m1_cnt_o (out, 32).
  - Each counter increments on every accepted transfer for its requester and saturates at 32'hFFFF_FFFF.
  - perf_clr_i synchronously zeroes both counters and has priority over increment.
  - Counters reset to 0.
- Without the macro: no such ports and no counters.

Decomposition:
- Shared package tcm_arb_pkg:
  - Requester ID constants REQ_CORE = 1'b0, REQ_EXT = 1'b1.
  - Default TAG_W = 11.
  - Default OUTSTANDING = 2.
- One natural sub-module: tcm_arb_id_fifo.
  - Synchronous-write, async-reset FIFO of 1-bit IDs.
  - Exposes push, pop, head, full and empty.

Test Plan:
- m0 read @0x2000_0010 tag 0x05 alone -> m0_accept_o = 1 in the same cycle; next cycle m0_ack_o = 1, tag 0x05, read data routed to m0; m1_ack_o = 0.
- m0 and m1 both requesting continuously for 6 cycles after reset -> grants m0, m1, m0, m1, m0, m1; every response routed to its issuer.
- m1 write wr = 4'hF to 0x1000_0004 while m0 idle -> tcm_wr_o = 4'hF, tcm_addr_o = 0x1000_0004; m1_ack_o next cycle; perf_m1_cnt_o = 1 when TCM_ARB_PERF_EN is set.
- TCM model withholds ack until 2 transfers are outstanding -> third request sees accept = 0 until the first ack cycle; in that cycle push and pop coexist and accept = 1.
- Spurious tcm_ack_i with FIFO empty -> err_o = 1 and stays 1; no mN_ack_o; rst_i pulse clears err_o.
- rst_i asserted asynchronously with 1 transfer outstanding -> FIFO empty; first post-reset contention grants m0.
